// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: fetches into IR, decodes, and
// sequences PC, bus mux, register loads and the A/G ALU registers.
module cpu_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8      // index fields are 3 bits, so at most 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_zero,
    output logic              pc_enable,
    output logic              pc_select,
    output logic [3:0]        bus_sel,
    output logic [NREGS-1:0]  reg_load,
    output logic              a_load,
    output logic              g_load,
    output logic              alu_sub,
    output logic              done,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_T1, S_T2, S_T3, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB  = 3'b011,
        OP_JMP = 3'b100, OP_JZ  = 3'b101, OP_NOP = 3'b110, OP_HALT = 3'b111
    } op_t;

    localparam logic [3:0] BUS_MEM  = 4'd8;
    localparam logic [3:0] BUS_G    = 4'd9;
    localparam logic [3:0] BUS_IDLE = 4'd15;

    state_t     state, state_nxt;
    // Only the op/rx/ry fields of the instruction word are kept; the low
    // seven bits carry no meaning for this sequencer.
    logic [8:0] ir;
    logic       z_flag;
    op_t        op;
    logic [2:0] rx, ry;
    logic       unused_ir_lo;

    assign op           = op_t'(ir[8:6]);
    assign rx           = ir[5:3];
    assign ry           = ir[2:0];
    assign unused_ir_lo = ^mem_data[DATA_W-10:0];

    // Out-of-range register indices select nothing for writes and R0 for reads.
    function automatic logic [NREGS-1:0] reg_dec(input logic [2:0] idx);
        reg_dec = '0;
        for (int i = 0; i < NREGS; i++)
            if (int'(idx) == i) reg_dec[i] = 1'b1;
    endfunction

    function automatic logic [3:0] reg_bus(input logic [2:0] idx);
        reg_bus = (int'(idx) < NREGS) ? {1'b0, idx} : 4'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ir     <= '0;
            z_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) ir     <= mem_data[DATA_W-1 -: 9];
            if (state == S_T2)    z_flag <= alu_zero;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_enable = 1'b0;
        pc_select = 1'b0;
        bus_sel   = BUS_IDLE;
        reg_load  = '0;
        a_load    = 1'b0;
        g_load    = 1'b0;
        alu_sub   = 1'b0;
        done      = 1'b0;
        halted    = 1'b0;

        case (state)
            S_IDLE: if (run) state_nxt = S_FETCH;

            S_FETCH: begin
                pc_enable = 1'b1;
                state_nxt = S_T1;
            end

            S_T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel  = reg_bus(ry);
                        reg_load = reg_dec(rx);
                        done     = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel   = BUS_MEM;
                        reg_load  = reg_dec(rx);
                        pc_enable = 1'b1;
                        done      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = reg_bus(rx);
                        a_load  = 1'b1;
                    end
                    OP_JMP: begin
                        bus_sel   = reg_bus(rx);
                        pc_select = 1'b1;
                        pc_enable = 1'b1;
                        done      = 1'b1;
                    end
                    OP_JZ: begin
                        // Not taken: PC already points past the JZ word.
                        if (z_flag) begin
                            bus_sel   = reg_bus(rx);
                            pc_select = 1'b1;
                            pc_enable = 1'b1;
                        end
                        done = 1'b1;
                    end
                    default: done = 1'b1;   // NOP, HALT
                endcase

                if (op == OP_HALT)
                    state_nxt = S_HALT;
                else if (op == OP_ADD || op == OP_SUB)
                    state_nxt = S_T2;
                else
                    state_nxt = run ? S_FETCH : S_IDLE;
            end

            S_T2: begin
                bus_sel   = reg_bus(ry);
                g_load    = 1'b1;
                alu_sub   = ir[6];
                state_nxt = S_T3;
            end

            S_T3: begin
                bus_sel   = BUS_G;
                reg_load  = reg_dec(rx);
                done      = 1'b1;
                state_nxt = run ? S_FETCH : S_IDLE;
            end

            S_HALT: halted = 1'b1;

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks instruction sequences cycle by cycle
// and compares the full output vector against hand-computed values.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, alu_zero;
    logic [15:0] mem_data;
    logic        pc_enable, pc_select, a_load, g_load, alu_sub, done, halted;
    logic [3:0]  bus_sel;
    logic [7:0]  reg_load;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer #(.DATA_W(16), .NREGS(8)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_data(mem_data), .alu_zero(alu_zero),
        .pc_enable(pc_enable), .pc_select(pc_select), .bus_sel(bus_sel),
        .reg_load(reg_load), .a_load(a_load), .g_load(g_load), .alu_sub(alu_sub),
        .done(done), .halted(halted)
    );

    always #5 clk = ~clk;

    // Packed output vector: pe ps bus[3:0] rl[7:0] al gl sub done halted
    logic [18:0] outs;
    assign outs = {pc_enable, pc_select, bus_sel, reg_load, a_load, g_load,
                   alu_sub, done, halted};

    function automatic logic [18:0] ex(input logic pe, input logic ps,
                                       input logic [3:0] bs, input logic [7:0] rl,
                                       input logic al, input logic gl,
                                       input logic sb, input logic dn,
                                       input logic h);
        ex = {pe, ps, bs, rl, al, gl, sb, dn, h};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [18:0] O_IDLE  = 19'({1'b0, 1'b0, 4'hF, 8'h00, 5'b00000});
    localparam logic [18:0] O_FETCH = 19'({1'b1, 1'b0, 4'hF, 8'h00, 5'b00000});
    localparam logic [18:0] O_HALT  = 19'({1'b0, 1'b0, 4'hF, 8'h00, 5'b00001});

    // Drive an instruction word, step into FETCH and check it, step into T1.
    task automatic fetch(input string tag, input logic [15:0] w);
        mem_data = w;
        tick;
        chk({tag, "_fetch"}, outs, O_FETCH);
        tick;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; alu_zero = 1'b0; mem_data = 16'h0000;
        tick; tick;
        chk("reset_idle", outs, O_IDLE);
        rst = 1'b0;
        tick;
        chk("idle_no_run", outs, O_IDLE);

        run = 1'b1;
        fetch("mvi", 16'h2400);
        chk("mvi_t1", outs, ex(1, 0, 4'd8, 8'h02, 0, 0, 0, 1, 0));

        fetch("add", 16'h4980);
        chk("add_t1", outs, ex(0, 0, 4'd2, 8'h00, 1, 0, 0, 0, 0));
        alu_zero = 1'b1;
        tick;
        chk("add_t2", outs, ex(0, 0, 4'd3, 8'h00, 0, 1, 0, 0, 0));
        tick;
        alu_zero = 1'b0;
        chk("add_t3", outs, ex(0, 0, 4'd9, 8'h04, 0, 0, 0, 1, 0));

        fetch("jz_taken", 16'hA000);
        chk("jz_taken_t1", outs, ex(1, 1, 4'd0, 8'h00, 0, 0, 0, 1, 0));

        fetch("sub", 16'h6980);
        chk("sub_t1", outs, ex(0, 0, 4'd2, 8'h00, 1, 0, 0, 0, 0));
        tick;
        chk("sub_t2", outs, ex(0, 0, 4'd3, 8'h00, 0, 1, 1, 0, 0));
        tick;
        chk("sub_t3", outs, ex(0, 0, 4'd9, 8'h04, 0, 0, 0, 1, 0));

        fetch("jz_not", 16'hA000);
        chk("jz_not_t1", outs, ex(0, 0, 4'hF, 8'h00, 0, 0, 0, 1, 0));

        fetch("mv01", 16'h0080);
        chk("mv_r0_r1_t1", outs, ex(0, 0, 4'd1, 8'h01, 0, 0, 0, 1, 0));

        fetch("mv70", 16'h1C00);
        chk("mv_r7_r0_t1", outs, ex(0, 0, 4'd0, 8'h80, 0, 0, 0, 1, 0));

        fetch("jmp", 16'h9400);
        chk("jmp_r5_t1", outs, ex(1, 1, 4'd5, 8'h00, 0, 0, 0, 1, 0));

        fetch("nop", 16'hC000);
        chk("nop_t1", outs, ex(0, 0, 4'hF, 8'h00, 0, 0, 0, 1, 0));

        fetch("halt", 16'hE000);
        chk("halt_t1", outs, ex(0, 0, 4'hF, 8'h00, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("halt_hold", outs, O_HALT);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("halt_rst_idle", outs, O_IDLE);

        // Set Z via an ADD, then reset mid-T2 of a second ADD; Z must clear.
        fetch("add_z", 16'h4980);
        alu_zero = 1'b1;
        tick; tick;
        chk("add_z_t3", outs, ex(0, 0, 4'd9, 8'h04, 0, 0, 0, 1, 0));
        fetch("add_r", 16'h4980);
        tick;
        chk("add_r_t2", outs, ex(0, 0, 4'd3, 8'h00, 0, 1, 0, 0, 0));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        alu_zero = 1'b0;
        chk("mid_t2_rst_idle", outs, O_IDLE);
        fetch("jz_after_rst", 16'hA000);
        chk("jz_after_rst_t1", outs, ex(0, 0, 4'hF, 8'h00, 0, 0, 0, 1, 0));

        // Dropping run mid-instruction lets it finish, then parks in IDLE.
        fetch("sub_drop", 16'h6980);
        tick;
        run = 1'b0;
        chk("sub_drop_t2", outs, ex(0, 0, 4'd3, 8'h00, 0, 1, 1, 0, 0));
        tick;
        chk("sub_drop_t3", outs, ex(0, 0, 4'd9, 8'h04, 0, 0, 0, 1, 0));
        tick;
        chk("drop_idle", outs, O_IDLE);
        tick;
        chk("drop_idle_hold", outs, O_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
